// File: rtl/vdp_host_port.sv
// vdp_host_port: CPU register port in front of the VDP write interface.
// Byte-wide register writes become single-cycle VRAM write strobes. It also
// provides an auto-incrementing address pointer and a fill engine that emits
// one strobe per cycle while busy.
module vdp_host_port #(
    parameter int         ADDR_WIDTH = 14,
    parameter logic [7:0] INCR_RESET = 8'd1
) (
    input  logic                  write_clk,
    input  logic                  reset,
    input  logic                  cpu_sel,
    input  logic                  cpu_we,
    input  logic [2:0]            cpu_reg,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [7:0]            write_data,
    output logic                  write_enable
);

    localparam logic [2:0] R_ADDR_LO  = 3'd0;
    localparam logic [2:0] R_ADDR_HI  = 3'd1;
    localparam logic [2:0] R_DATA     = 3'd2;
    localparam logic [2:0] R_INCR     = 3'd3;
    localparam logic [2:0] R_FILL_LO  = 3'd4;
    localparam logic [2:0] R_FILL_HI  = 3'd5;
    localparam logic [2:0] R_FILL_VAL = 3'd6;
    localparam logic [2:0] R_CTRL     = 3'd7;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            incr_q, incr_d;
    logic [ADDR_WIDTH-1:0] fill_count_q, fill_count_d;
    logic [7:0]            fill_val_q, fill_val_d;
    logic                  overflow_q, overflow_d;
    // Strobe from a DATA register write, registered one cycle after the access.
    logic                  dstb_q, dstb_d;
    logic [ADDR_WIDTH-1:0] dwaddr_q, dwaddr_d;
    logic [7:0]            dwdata_q, dwdata_d;
    logic [7:0]            rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0] incr_ext;
    logic [7:0]            rd_mux;
    logic                  filling;

    assign incr_ext = {{(ADDR_WIDTH-8){1'b0}}, incr_q};
    assign filling  = (state_q == FILL);

    // Fill strobes come straight from the FILL state so the first one lands in
    // the cycle right after START and each strobe shares its cycle with busy.
    assign busy         = filling;
    assign write_enable = dstb_q | filling;
    assign write_addr   = filling ? addr_q : dwaddr_q;
    assign write_data   = filling ? fill_val_q : dwdata_q;
    assign cpu_rdata    = rdata_q;

    // Read-back mux; DATA is write-only and reads as zero.
    always_comb begin
        rd_mux = 8'h00;
        case (cpu_reg)
            R_ADDR_LO:  rd_mux = addr_q[7:0];
            R_ADDR_HI:  rd_mux = 8'(addr_q[ADDR_WIDTH-1:8]);
            R_DATA:     rd_mux = 8'h00;
            R_INCR:     rd_mux = incr_q;
            R_FILL_LO:  rd_mux = fill_count_q[7:0];
            R_FILL_HI:  rd_mux = 8'(fill_count_q[ADDR_WIDTH-1:8]);
            R_FILL_VAL: rd_mux = fill_val_q;
            R_CTRL:     rd_mux = {6'b0, overflow_q, filling};
            default:    rd_mux = 8'h00;
        endcase
    end

    // Next-state: fill progression, register writes, reads and FSM.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        incr_d       = incr_q;
        fill_count_d = fill_count_q;
        fill_val_d   = fill_val_q;
        overflow_d   = overflow_q;
        dstb_d       = 1'b0;
        dwaddr_d     = dwaddr_q;
        dwdata_d     = dwdata_q;
        rdata_d      = rdata_q;

        // Each FILL cycle issues a strobe at the current address and consumes it.
        if (filling) begin
            addr_d       = addr_q + incr_ext;
            fill_count_d = fill_count_q - 1'b1;
            if (fill_count_q == {{(ADDR_WIDTH-1){1'b0}}, 1'b1})
                state_d = IDLE;
        end

        if (cpu_sel && !cpu_we)
            rdata_d = rd_mux;

        if (cpu_sel && cpu_we) begin
            if (filling) begin
                // Only CLR_OVF and ABORT are honoured mid-fill; anything else is lost.
                if (cpu_reg == R_CTRL) begin
                    if (cpu_wdata[1]) overflow_d = 1'b0;
                    if (cpu_wdata[2]) state_d    = IDLE;
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                case (cpu_reg)
                    R_ADDR_LO:  addr_d[7:0] = cpu_wdata;
                    R_ADDR_HI:  addr_d[ADDR_WIDTH-1:8] = cpu_wdata[ADDR_WIDTH-9:0];
                    R_DATA: begin
                        dstb_d   = 1'b1;
                        dwaddr_d = addr_q;
                        dwdata_d = cpu_wdata;
                        addr_d   = addr_q + incr_ext;
                    end
                    R_INCR:     incr_d = cpu_wdata;
                    R_FILL_LO:  fill_count_d[7:0] = cpu_wdata;
                    R_FILL_HI:  fill_count_d[ADDR_WIDTH-1:8] = cpu_wdata[ADDR_WIDTH-9:0];
                    R_FILL_VAL: fill_val_d = cpu_wdata;
                    R_CTRL: begin
                        if (cpu_wdata[1]) overflow_d = 1'b0;
                        if (cpu_wdata[0] && (fill_count_q != '0)) state_d = FILL;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            incr_q       <= INCR_RESET;
            fill_count_q <= '0;
            fill_val_q   <= 8'h00;
            overflow_q   <= 1'b0;
            dstb_q       <= 1'b0;
            dwaddr_q     <= '0;
            dwdata_q     <= 8'h00;
            rdata_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            incr_q       <= incr_d;
            fill_count_q <= fill_count_d;
            fill_val_q   <= fill_val_d;
            overflow_q   <= overflow_d;
            dstb_q       <= dstb_d;
            dwaddr_q     <= dwaddr_d;
            dwdata_q     <= dwdata_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_vdp_host_port.sv
// Bench for vdp_host_port: directed scenarios with literal expectations plus
// randomized register traffic compared cycle by cycle to a behavioural model.
module tb_vdp_host_port;

    logic        write_clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_sel = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  cpu_reg = 3'd0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        busy;
    logic [13:0] write_addr;
    logic [7:0]  write_data;
    logic        write_enable;

    vdp_host_port #(.ADDR_WIDTH(14), .INCR_RESET(8'd1)) dut (
        .write_clk(write_clk), .reset(reset), .cpu_sel(cpu_sel), .cpu_we(cpu_we),
        .cpu_reg(cpu_reg), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .busy(busy),
        .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable)
    );

    always #5 write_clk = ~write_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: register file plus fill progress, stepped per clock.
    int       m_addr, m_incr, m_cnt, m_val;
    bit       m_ovf, m_fill, m_dstb, m_rvalid, m_wf;
    int       m_daddr, m_ddata;
    logic [7:0] m_rdata;

    function automatic logic [7:0] regval(input logic [2:0] r);
        case (r)
            3'd0:    return 8'(m_addr % 256);
            3'd1:    return 8'(m_addr / 256);
            3'd3:    return 8'(m_incr);
            3'd4:    return 8'(m_cnt % 256);
            3'd5:    return 8'(m_cnt / 256);
            3'd6:    return 8'(m_val);
            3'd7:    return {6'b0, m_ovf, m_fill};
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge write_clk or posedge reset) begin
        if (reset) begin
            m_addr = 0; m_incr = 1; m_cnt = 0; m_val = 0;
            m_ovf = 0; m_fill = 0; m_dstb = 0; m_rvalid = 0;
            m_daddr = 0; m_ddata = 0; m_rdata = 8'h00;
        end else begin
            m_rvalid = 0;
            m_dstb   = 0;
            if (cpu_sel && !cpu_we) begin
                m_rvalid = 1;
                m_rdata  = regval(cpu_reg);
            end
            m_wf = m_fill;
            if (m_wf) begin
                m_addr = (m_addr + m_incr) % 16384;
                m_cnt  = m_cnt - 1;
                if (m_cnt == 0) m_fill = 0;
            end
            if (cpu_sel && cpu_we) begin
                if (m_wf) begin
                    if (cpu_reg == 3'd7) begin
                        if (cpu_wdata[1]) m_ovf = 0;
                        if (cpu_wdata[2]) m_fill = 0;
                    end else m_ovf = 1;
                end else begin
                    case (cpu_reg)
                        3'd0: m_addr = (m_addr / 256) * 256 + cpu_wdata;
                        3'd1: m_addr = (m_addr % 256) + (cpu_wdata % 64) * 256;
                        3'd2: begin
                            m_dstb = 1; m_daddr = m_addr; m_ddata = cpu_wdata;
                            m_addr = (m_addr + m_incr) % 16384;
                        end
                        3'd3: m_incr = cpu_wdata;
                        3'd4: m_cnt = (m_cnt / 256) * 256 + cpu_wdata;
                        3'd5: m_cnt = (m_cnt % 256) + (cpu_wdata % 64) * 256;
                        3'd6: m_val = cpu_wdata;
                        default: begin
                            if (cpu_wdata[1]) m_ovf = 0;
                            if (cpu_wdata[0] && m_cnt != 0) m_fill = 1;
                        end
                    endcase
                end
            end
        end
    end

    // Compare process: every cycle out of reset, DUT outputs against the model.
    always @(negedge write_clk) begin
        if (!reset) begin
            chk("write_enable", write_enable, m_dstb || m_fill);
            chk("busy", busy, m_fill);
            if (m_fill) begin
                chk("fill_addr", write_addr, m_addr);
                chk("fill_data", write_data, m_val);
            end else if (m_dstb) begin
                chk("data_addr", write_addr, m_daddr);
                chk("data_data", write_data, m_ddata);
            end
            if (m_rvalid) chk("cpu_rdata", cpu_rdata, m_rdata);
        end
    end

    // Strobe log and busy counter for the directed literal checks.
    typedef struct { int a; int d; int t; } strobe_t;
    strobe_t obs[$];
    int      cyc_cnt = 0;
    int      busy_cnt = 0;

    always @(posedge write_clk) cyc_cnt++;

    always @(negedge write_clk) begin
        if (!reset && write_enable === 1'b1) obs.push_back('{int'(write_addr), int'(write_data), cyc_cnt});
        if (!reset && busy === 1'b1) busy_cnt++;
    end

    task automatic cyc(input bit s, input bit w, input logic [2:0] r, input logic [7:0] d);
        @(negedge write_clk);
        cpu_sel = s; cpu_we = w; cpu_reg = r; cpu_wdata = d;
    endtask

    task automatic wr(input logic [2:0] r, input logic [7:0] d);
        cyc(1, 1, r, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 3'd0, 8'h00);
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] r, input logic [7:0] exp);
        cyc(1, 0, r, 8'h00);
        cyc(0, 0, 3'd0, 8'h00);
        chk(nm, cpu_rdata, exp);
    endtask

    int n0, n77;

    initial begin
        repeat (3) @(negedge write_clk);
        reset = 1'b0;
        chk("rst_we", write_enable, 0);
        chk("rst_addr", write_addr, 0);
        chk("rst_data", write_data, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_busy", busy, 0);
        rd_chk("rst_reg7", 3'd7, 8'h00);
        rd_chk("rst_reg3", 3'd3, 8'h01);

        // Two back-to-back DATA writes.
        obs.delete();
        wr(3'd1, 8'h12); wr(3'd0, 8'h34); wr(3'd2, 8'hAA); wr(3'd2, 8'h55);
        idle(3);
        chk("data_n", obs.size(), 2);
        if (obs.size() >= 2) begin
            chk("data0_a", obs[0].a, 'h1234); chk("data0_d", obs[0].d, 'hAA);
            chk("data1_a", obs[1].a, 'h1235); chk("data1_d", obs[1].d, 'h55);
            chk("data_b2b", obs[1].t - obs[0].t, 1);
        end
        rd_chk("addr_lo", 3'd0, 8'h36);
        rd_chk("addr_hi", 3'd1, 8'h12);

        // Address wrap with a large increment.
        wr(3'd3, 8'h40); wr(3'd1, 8'h3F); wr(3'd0, 8'hF0);
        obs.delete();
        wr(3'd2, 8'h01);
        idle(2);
        chk("wrap_n", obs.size(), 1);
        if (obs.size() >= 1) chk("wrap_a", obs[0].a, 'h3FF0);
        rd_chk("wrap_lo", 3'd0, 8'h30);
        rd_chk("wrap_hi", 3'd1, 8'h00);

        // Five-byte fill.
        wr(3'd6, 8'hE5); wr(3'd4, 8'h05); wr(3'd5, 8'h00); wr(3'd3, 8'h01);
        wr(3'd1, 8'h01); wr(3'd0, 8'h00);
        obs.delete(); busy_cnt = 0;
        wr(3'd7, 8'h01);
        idle(8);
        chk("fill_n", obs.size(), 5);
        chk("fill_busy", busy_cnt, 5);
        for (int i = 0; i < obs.size() && i < 5; i++) begin
            chk("fill_a", obs[i].a, 'h100 + i);
            chk("fill_d", obs[i].d, 'hE5);
        end
        rd_chk("fill_reg7", 3'd7, 8'h00);
        rd_chk("fill_lo", 3'd0, 8'h05);
        rd_chk("fill_hi", 3'd1, 8'h01);

        // Misuse during a 100-byte fill, then abort and clear overflow.
        obs.delete();
        wr(3'd4, 8'd100); wr(3'd5, 8'h00); wr(3'd7, 8'h01);
        idle(3);
        wr(3'd2, 8'h77);
        rd_chk("ovf_reg7", 3'd7, 8'h03);
        wr(3'd7, 8'h04);
        idle(1);
        chk("abort_busy", busy, 0);
        n0 = obs.size();
        idle(5);
        chk("abort_stop", obs.size(), n0);
        n77 = 0;
        foreach (obs[i]) if (obs[i].d == 'h77) n77++;
        chk("no_77", n77, 0);
        rd_chk("abort_reg7", 3'd7, 8'h02);
        wr(3'd7, 8'h02);
        rd_chk("clr_reg7", 3'd7, 8'h00);

        // Reset mid-fill: strobe drops before any clock edge.
        wr(3'd4, 8'd50); wr(3'd7, 8'h01);
        idle(3);
        #2;
        chk("pre_rst_we", write_enable, 1);
        reset = 1'b1;
        #1;
        chk("async_we", write_enable, 0);
        chk("async_busy", busy, 0);
        @(negedge write_clk);
        reset = 1'b0;
        for (int r = 0; r < 8; r++)
            if (r != 2) rd_chk("post_rst_reg", 3'(r), (r == 3) ? 8'h01 : 8'h00);

        // START with zero count is a no-op.
        obs.delete(); busy_cnt = 0;
        wr(3'd7, 8'h01);
        idle(3);
        chk("zero_start_n", obs.size(), 0);
        chk("zero_start_busy", busy_cnt, 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 800; k++) begin
            logic [2:0] r;
            logic [7:0] d;
            bit         w;
            r = 3'($urandom_range(0, 7));
            w = ($urandom % 4) != 0;
            d = 8'($urandom);
            if (w && r == 3'd5) d = (($urandom % 8) == 0) ? 8'h01 : 8'h00;
            if (w && r == 3'd7) d = {5'b0, (($urandom % 6) == 0), 1'($urandom), 1'($urandom)};
            if (!w && r == 3'd2) r = 3'd0;
            cyc(1, w, r, d);
            idle($urandom_range(0, 2));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
